// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main controller: fetch/decode/execute/mem/writeback FSM
// with configurable memory read latency and illegal-op/overflow exceptions.
module mips_mc_control #(
  parameter int MEM_LAT = 1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ALU_zero,
  input  logic       ALU_overflow,
  output logic       PC_load,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       wr,
  output logic       IR_load,
  output logic       MDR_load,
  output logic       A_load,
  output logic       B_load,
  output logic       ALUOut_load,
  output logic       EPC_load,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_sel,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [3:0] state
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_RWB    = 4'd4,
    S_EXEC_I = 4'd5,
    S_IWB    = 4'd6,
    S_ADDR   = 4'd7,
    S_MEMRD  = 4'd8,
    S_MWB    = 4'd9,
    S_MEMWR  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_EXC    = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last;
  logic          r_ok;

  assign cnt_last = (cnt_q == CW'(MEM_LAT - 1));
  assign r_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                (funct == FN_AND);
  assign state = state_q;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = S_RESET;
    cnt_d       = '0;
    PC_load     = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    wr          = 1'b0;
    IR_load     = 1'b0;
    MDR_load    = 1'b0;
    A_load      = 1'b0;
    B_load      = 1'b0;
    ALUOut_load = 1'b0;
    EPC_load    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_sel     = 3'b000;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        ALUSrcB = 2'b01;
        ALU_sel = 3'b001;
        if (cnt_last) begin
          IR_load = 1'b1;
          PC_load = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        A_load      = 1'b1;
        B_load      = 1'b1;
        ALUOut_load = 1'b1;
        ALUSrcB     = 2'b11;
        ALU_sel     = 3'b001;
        case (opcode)
          OP_R:         state_d = r_ok ? S_EXEC_R : S_EXC;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ,
          OP_BNE:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_EXEC_I;
          default:      state_d = S_EXC;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA     = 1'b1;
        ALUOut_load = 1'b1;
        case (funct)
          FN_ADD:  ALU_sel = 3'b001;
          FN_SUB:  ALU_sel = 3'b010;
          FN_AND:  ALU_sel = 3'b011;
          default: ALU_sel = 3'b000;
        endcase
        // and cannot overflow; only add/sub trap
        if (ALU_overflow && (funct != FN_AND)) state_d = S_EXC;
        else                                   state_d = S_RWB;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_sel     = 3'b001;
        ALUOut_load = 1'b1;
        state_d     = ALU_overflow ? S_EXC : S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_sel     = 3'b001;
        ALUOut_load = 1'b1;
        state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        if (cnt_last) begin
          MDR_load = 1'b1;
          state_d  = S_MWB;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_MEMRD;
        end
      end
      S_MWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        IorD    = 1'b1;
        wr      = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALU_sel  = 3'b111;
        PCSource = 2'b01;
        PC_load  = (opcode == OP_BNE) ? !ALU_zero : ALU_zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PC_load  = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXC: begin
        ALUSrcB  = 2'b01;
        ALU_sel  = 3'b010;
        EPC_load = 1'b1;
        PC_load  = 1'b1;
        PCSource = 2'b11;
        state_d  = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule
